seq_divider_2n_by_n: RTL and testbench



---
 rtl/seq_divider_2n_by_n.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider_2n_by_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_2n_by_n.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock, valid/ready on both
// sides. Divide-by-zero and quotient overflow are flagged with fixed error
// values (quotient all ones, remainder = dividend low half).
// Optional feature macro: DIV_SIGNED_EN (two's complement operands,
// truncating division). Default build is unsigned only.
module seq_divider_2n_by_n #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           err_div0,
  output logic           err_ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;   // partial remainder (upper half)
  logic [N-1:0]  dvd_q, dvd_d;   // dividend low half, quotient bits shift in
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          e0_q, e0_d;
  logic          ov_q, ov_d;

`ifdef DIV_SIGNED_EN
  localparam logic [N-1:0] QPOS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] QNEG_MAX = {1'b1, {(N-1){1'b0}}};
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [N-1:0]  dlo_q, dlo_d;   // original dividend low half for error result
`endif

  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dsr_mag;
  logic [N:0]     upper;
  logic [N:0]     trial;
  logic           trial_ok;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   qbits;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign err_div0  = e0_q;
  assign err_ovf   = ov_q;

  // Operand magnitudes; identity in the unsigned build
  always_comb begin
`ifdef DIV_SIGNED_EN
    dvd_mag = dividend[2*N-1] ? -dividend : dividend;
    dsr_mag = divisor[N-1] ? -divisor : divisor;
`else
    dvd_mag = dividend;
    dsr_mag = divisor;
`endif
  end

  // One restoring step: shift in next dividend bit, N+1-bit trial subtract
  always_comb begin
    upper    = {rem_q, dvd_q[N-1]};
    trial    = upper - {1'b0, div_q};
    trial_ok = ~trial[N];
    rem_next = trial_ok ? trial[N-1:0] : upper[N-1:0];
    qbits    = {dvd_q[N-2:0], trial_ok};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    e0_d    = e0_q;
    ov_d    = ov_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dlo_d   = dlo_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d = dvd_mag[2*N-1:N];
          dvd_d = dvd_mag[N-1:0];
          div_d = dsr_mag;
          cnt_d = CW'(N - 1);
          e0_d  = 1'b0;
          ov_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          qneg_d = dividend[2*N-1] ^ divisor[N-1];
          rneg_d = dividend[2*N-1];
          dlo_d  = dividend[N-1:0];
`endif
          if (dsr_mag == '0) begin
            state_d = DONE;
            e0_d    = 1'b1;
            quo_d   = '1;
            rmd_d   = dividend[N-1:0];
          end else if (dvd_mag[2*N-1:N] >= dsr_mag) begin
            state_d = DONE;
            ov_d    = 1'b1;
            quo_d   = '1;
            rmd_d   = dividend[N-1:0];
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        dvd_d = qbits;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef DIV_SIGNED_EN
          if (qneg_q ? (qbits > QNEG_MAX) : (qbits > QPOS_MAX)) begin
            ov_d  = 1'b1;
            quo_d = '1;
            rmd_d = dlo_q;
          end else begin
            quo_d = qneg_q ? -qbits : qbits;
            rmd_d = rneg_q ? -rem_next : rem_next;
          end
`else
          quo_d = qbits;
          rmd_d = rem_next;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          e0_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      e0_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      e0_q    <= e0_d;
      ov_q    <= ov_d;
    end
  end

  // Working datapath registers; contents are only meaningful while in CALC
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dvd_q  <= dvd_d;
    div_q  <= div_d;
`ifdef DIV_SIGNED_EN
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dlo_q  <= dlo_d;
`endif
  end

endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Directed bench for seq_divider_2n_by_n (N=8) with a short random run.
module tb_seq_divider_2n_by_n;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err_div0;
  logic        err_ovf;

  int total = 0;
  int bad = 0;
  int lat = 0;

  always #5 clk = ~clk;

  seq_divider_2n_by_n #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .err_div0(err_div0), .err_ovf(err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and wait (bounded) for out_valid
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    chk("in_ready_idle", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input int elat, input logic [7:0] q,
                            input logic [7:0] r, input logic e0, input logic ov);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_div0"}, err_div0, e0);
    chk({tag, "_ovf"}, err_ovf, ov);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("ovalid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [7:0]  hi;
    int          prod;
    int          seen;

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_div0", err_div0, 0);
    chk("rst_ovf", err_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 12345 / 123 = 100 r 45
    send(16'h3039, 8'h7B);
    expect_res("u_3039", 9, 8'h64, 8'h2D, 0, 0);
    handshake();

    // Divide by zero
    send(16'h00FF, 8'h00);
    expect_res("div0", 1, 8'hFF, 8'hFF, 1, 0);
    handshake();

    // Upper half equals divisor -> overflow
    send(16'h1234, 8'h12);
    expect_res("ovf", 1, 8'hFF, 8'h34, 0, 1);
    handshake();

`ifndef DIV_SIGNED_EN
    // 255*255 = 65025
    send(16'hFE01, 8'hFF);
    expect_res("u_fe01", 9, 8'hFF, 8'h00, 0, 0);
    handshake();
    // 4607 / 18 = 255 r 17, largest quotient without overflow
    send(16'h11FF, 8'h12);
    expect_res("u_11ff", 9, 8'hFF, 8'h11, 0, 0);
    handshake();
`else
    // -100 / 7 = -14 r -2
    send(16'hFF9C, 8'h07);
    expect_res("s_m100", 9, 8'hF2, 8'hFE, 0, 0);
    handshake();
    // 100 / -7 = -14 r 2
    send(16'h0064, 8'hF9);
    expect_res("s_100n7", 9, 8'hF2, 8'h02, 0, 0);
    handshake();
    // -128 / 1 fits exactly
    send(16'hFF80, 8'h01);
    expect_res("s_m128", 9, 8'h80, 8'h00, 0, 0);
    handshake();
    // +128 / 1 does not fit
    send(16'h0080, 8'h01);
    expect_res("s_p128", 9, 8'hFF, 8'h80, 0, 1);
    handshake();
`endif

    // Backpressure and busy-time in_valid: 4000 / 64 = 62 r 32
    chk("bp_in_ready", in_ready, 1);
    dividend = 16'h0FA0;
    divisor  = 8'h40;
    in_valid = 1'b1;
    cyc();
    for (int i = 0; i < N; i++) begin
      chk("busy_in_ready", in_ready, 0);
      chk("busy_out_valid", out_valid, 0);
      in_valid = i[0];
      dividend = 16'hFFFF - 16'(i);
      divisor  = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_q", quotient, 8'h3E);
      chk("bp_hold_r", remainder, 8'h20);
      chk("bp_hold_flags", {err_div0, err_ovf}, 2'b00);
      chk("bp_hold_in_ready", in_ready, 0);
      cyc();
      chk("bp_hold_valid", out_valid, 1);
    end
    handshake();

    // Asynchronous reset in the middle of a division
    dividend = 16'h3039;
    divisor  = 8'h7B;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_flags", {err_div0, err_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (out_valid) seen++;
    end
    chk("no_stale_result", seen, 0);
    send(16'h0064, 8'h07);
    expect_res("post_rst", 9, 8'h0E, 8'h02, 0, 0);
    handshake();

`ifndef DIV_SIGNED_EN
    // Random unsigned pairs with random output backpressure
    for (int i = 0; i < 300; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (i % 4 == 0 || rb == 8'h00) hi = 8'($urandom_range(0, 255));
      else hi = 8'($urandom_range(0, int'(rb) - 1));
      ra = {hi, 8'($urandom_range(0, 255))};
      send(ra, rb);
      if (rb == 8'h00) begin
        expect_res("rnd_div0", 1, 8'hFF, ra[7:0], 1, 0);
      end else if (ra[15:8] >= rb) begin
        expect_res("rnd_ovf", 1, 8'hFF, ra[7:0], 0, 1);
      end else begin
        prod = int'(quotient) * int'(rb) + int'(remainder);
        chk("rnd_lat", lat, 9);
        chk("rnd_invariant", 32'(prod), 32'(ra));
        chk("rnd_rem_lt_div", (remainder < rb), 1);
        chk("rnd_flags", {err_div0, err_ovf}, 2'b00);
      end
      repeat ($urandom_range(0, 3)) cyc();
      chk("rnd_valid_held", out_valid, 1);
      handshake();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
